// File: rtl/aq_mmu_utlb_arb.sv
// Arbiter between the I-side and D-side micro-TLB refill requests for a single
// JTLB lookup port; grants one owner at a time and holds its fields until it completes.
module aq_mmu_utlb_arb (
    input  logic        mmu_top_clk,
    input  logic        cpurst_b,
    input  logic        iutlb_arb_req,
    input  logic [27:0] iutlb_arb_vpn,
    input  logic [15:0] iutlb_arb_asid,
    input  logic [1:0]  iutlb_arb_mode,
    input  logic        iutlb_arb_mach,
    input  logic        iutlb_arb_cmplt,
    input  logic        dutlb_arb_req,
    input  logic [27:0] dutlb_arb_vpn,
    input  logic [15:0] dutlb_arb_asid,
    input  logic [1:0]  dutlb_arb_mode,
    input  logic        dutlb_arb_mach,
    input  logic        dutlb_arb_read,
    input  logic        dutlb_arb_cmplt,
    input  logic        cp0_mmu_lpmd_req,
    output logic        arb_iutlb_grant,
    output logic        arb_dutlb_grant,
    output logic        arb_jtlb_req,
    output logic [27:0] arb_jtlb_vpn,
    output logic [15:0] arb_jtlb_asid,
    output logic [1:0]  arb_jtlb_mode,
    output logic        arb_jtlb_mach,
    output logic        arb_jtlb_read,
    output logic        arb_jtlb_src,
    output logic [1:0]  arb_top_cur_st,
    output logic        arb_cp0_no_op
);

    localparam int unsigned VPN_W  = 28;
    localparam int unsigned ASID_W = 16;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_BUSY  = 2'b10
    } arb_st_e;

    arb_st_e             cur_st;
    logic                last_src;
    logic                src;
    logic [VPN_W-1:0]    vpn_q;
    logic [ASID_W-1:0]   asid_q;
    logic [MODE_W-1:0]   mode_q;
    logic                mach_q;
    logic                read_q;

    logic in_idle;
    logic can_grant;
    logic i_win;
    logic d_win;
    logic owner_cmplt;

    // Grants are decoded in the IDLE cycle itself; a tie goes to the side not served last.
    assign in_idle     = (cur_st == ST_IDLE);
    assign can_grant   = cpurst_b & in_idle & ~cp0_mmu_lpmd_req;
    assign i_win       = can_grant & iutlb_arb_req & (~dutlb_arb_req | last_src);
    assign d_win       = can_grant & dutlb_arb_req & (~iutlb_arb_req | ~last_src);
    assign owner_cmplt = src ? dutlb_arb_cmplt : iutlb_arb_cmplt;

    always_ff @(posedge mmu_top_clk) begin
        if (!cpurst_b) begin
            cur_st   <= ST_IDLE;
            last_src <= 1'b1;
            src      <= 1'b0;
            vpn_q    <= '0;
            asid_q   <= '0;
            mode_q   <= '0;
            mach_q   <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            case (cur_st)
                ST_IDLE: begin
                    if (i_win) begin
                        cur_st   <= ST_GRANT;
                        last_src <= 1'b0;
                        src      <= 1'b0;
                        vpn_q    <= iutlb_arb_vpn;
                        asid_q   <= iutlb_arb_asid;
                        mode_q   <= iutlb_arb_mode;
                        mach_q   <= iutlb_arb_mach;
                        read_q   <= 1'b1;
                    end else if (d_win) begin
                        cur_st   <= ST_GRANT;
                        last_src <= 1'b1;
                        src      <= 1'b1;
                        vpn_q    <= dutlb_arb_vpn;
                        asid_q   <= dutlb_arb_asid;
                        mode_q   <= dutlb_arb_mode;
                        mach_q   <= dutlb_arb_mach;
                        read_q   <= dutlb_arb_read;
                    end
                end
                ST_GRANT: cur_st <= ST_BUSY;
                // Only the current owner's completion releases the port.
                ST_BUSY: begin
                    if (owner_cmplt) begin
                        cur_st <= ST_IDLE;
                    end
                end
                default: cur_st <= ST_IDLE;
            endcase
        end
    end

    assign arb_iutlb_grant = i_win;
    assign arb_dutlb_grant = d_win;
    assign arb_jtlb_req    = cpurst_b & (cur_st == ST_GRANT);
    assign arb_jtlb_vpn    = vpn_q;
    assign arb_jtlb_asid   = asid_q;
    assign arb_jtlb_mode   = mode_q;
    assign arb_jtlb_mach   = mach_q;
    assign arb_jtlb_read   = read_q;
    assign arb_jtlb_src    = src;
    assign arb_top_cur_st  = cur_st;
    assign arb_cp0_no_op   = in_idle & ~iutlb_arb_req & ~dutlb_arb_req;

endmodule

// File: tb/tb_aq_mmu_utlb_arb.sv
// Directed bench for aq_mmu_utlb_arb: expected JTLB lookups are queued at grant time
// and a negedge monitor compares them whenever arb_jtlb_req is presented.
module tb_aq_mmu_utlb_arb;

    typedef struct packed {
        logic        src;
        logic [27:0] vpn;
        logic [15:0] asid;
        logic [1:0]  mode;
        logic        mach;
        logic        read;
    } exp_t;

    logic        clk;
    logic        rst_b;
    logic        ireq, dreq, imach, dmach, dread, icmplt, dcmplt, lpmd;
    logic [27:0] ivpn, dvpn;
    logic [15:0] iasid, dasid;
    logic [1:0]  imode, dmode;

    logic        igrant, dgrant, jreq, jmach, jread, jsrc, no_op;
    logic [27:0] jvpn;
    logic [15:0] jasid;
    logic [1:0]  jmode, cur_st;

    int   checks;
    int   failures;
    exp_t sb[$];

    aq_mmu_utlb_arb dut (
        .mmu_top_clk      (clk),
        .cpurst_b         (rst_b),
        .iutlb_arb_req    (ireq),
        .iutlb_arb_vpn    (ivpn),
        .iutlb_arb_asid   (iasid),
        .iutlb_arb_mode   (imode),
        .iutlb_arb_mach   (imach),
        .iutlb_arb_cmplt  (icmplt),
        .dutlb_arb_req    (dreq),
        .dutlb_arb_vpn    (dvpn),
        .dutlb_arb_asid   (dasid),
        .dutlb_arb_mode   (dmode),
        .dutlb_arb_mach   (dmach),
        .dutlb_arb_read   (dread),
        .dutlb_arb_cmplt  (dcmplt),
        .cp0_mmu_lpmd_req (lpmd),
        .arb_iutlb_grant  (igrant),
        .arb_dutlb_grant  (dgrant),
        .arb_jtlb_req     (jreq),
        .arb_jtlb_vpn     (jvpn),
        .arb_jtlb_asid    (jasid),
        .arb_jtlb_mode    (jmode),
        .arb_jtlb_mach    (jmach),
        .arb_jtlb_read    (jread),
        .arb_jtlb_src     (jsrc),
        .arb_top_cur_st   (cur_st),
        .arb_cp0_no_op    (no_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every JTLB request must match the oldest queued expectation.
    always @(negedge clk) begin
        if (jreq === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL jtlb_req_unexpected actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("jtlb_src",  32'(jsrc),  32'(e.src));
                chk("jtlb_vpn",  32'(jvpn),  32'(e.vpn));
                chk("jtlb_asid", 32'(jasid), 32'(e.asid));
                chk("jtlb_mode", 32'(jmode), 32'(e.mode));
                chk("jtlb_mach", 32'(jmach), 32'(e.mach));
                chk("jtlb_read", 32'(jread), 32'(e.read));
            end
        end
    end

    initial begin
        checks = 0; failures = 0;
        rst_b = 1'b0; ireq = 0; dreq = 0; imach = 0; dmach = 0; dread = 0;
        icmplt = 0; dcmplt = 0; lpmd = 0;
        ivpn = '0; dvpn = '0; iasid = '0; dasid = '0; imode = '0; dmode = '0;

        // Reset: requests held high while in reset must not be granted.
        step(); step();
        ireq = 1; dreq = 1;
        #3;
        chk("rst_igrant", 32'(igrant), 0);
        chk("rst_dgrant", 32'(dgrant), 0);
        chk("rst_state",  32'(cur_st), 0);
        chk("rst_no_op_busy_req", 32'(no_op), 0);
        chk("rst_jreq",   32'(jreq),   0);
        chk("rst_vpn",    32'(jvpn),   0);
        chk("rst_src",    32'(jsrc),   0);
        ireq = 0; dreq = 0;
        step();
        rst_b = 1'b1;
        #3;
        chk("rst_no_op", 32'(no_op), 1);

        // Tie after reset: iutlb first, dutlb three cycles later with read=0.
        step();
        ireq = 1; dreq = 1;
        ivpn = 28'h0000111; iasid = 16'h1111; imode = 2'b01; imach = 0;
        dvpn = 28'hfedcba9; dasid = 16'hbeef; dmode = 2'b10; dmach = 1; dread = 0;
        sb.push_back(exp_t'{1'b0, 28'h0000111, 16'h1111, 2'b01, 1'b0, 1'b1});
        #3;
        chk("tie_igrant", 32'(igrant), 1);
        chk("tie_dgrant_lose", 32'(dgrant), 0);
        step(); ireq = 0; #3;
        chk("tie_st_grant", 32'(cur_st), 1);
        chk("tie_no_grant_in_grant", 32'(dgrant), 0);
        step(); icmplt = 1; #3;
        chk("tie_st_busy", 32'(cur_st), 2);
        chk("tie_no_grant_in_busy", 32'(dgrant), 0);
        step(); icmplt = 0;
        sb.push_back(exp_t'{1'b1, 28'hfedcba9, 16'hbeef, 2'b10, 1'b1, 1'b0});
        #3;
        chk("tie_st_idle", 32'(cur_st), 0);
        chk("tie_dgrant_after3", 32'(dgrant), 1);
        chk("tie_igrant_none", 32'(igrant), 0);
        step(); dreq = 0; #3;
        chk("d_st_grant", 32'(cur_st), 1);
        step(); #3;
        chk("d_st_busy", 32'(cur_st), 2);
        chk("d_busy_src", 32'(jsrc), 1);
        chk("d_busy_read", 32'(jread), 0);
        dcmplt = 1;
        step(); dcmplt = 0; #3;
        chk("d_back_idle", 32'(cur_st), 0);

        // Single I-side request, cmplt ignored in GRANT, wrong completion in BUSY.
        step();
        ireq = 1; ivpn = 28'h1234567; iasid = 16'h00a5; imode = 2'b11; imach = 1;
        sb.push_back(exp_t'{1'b0, 28'h1234567, 16'h00a5, 2'b11, 1'b1, 1'b1});
        #3;
        chk("single_igrant", 32'(igrant), 1);
        chk("single_st_idle", 32'(cur_st), 0);
        step(); ireq = 0; icmplt = 1; #3;
        chk("single_st_grant", 32'(cur_st), 1);
        step(); icmplt = 0; dcmplt = 1; #3;
        chk("single_st_busy", 32'(cur_st), 2);
        step(); dcmplt = 0; #3;
        chk("wrong_cmplt_stay_busy", 32'(cur_st), 2);
        chk("busy_vpn_stable", 32'(jvpn), 32'h1234567);
        chk("busy_read_i", 32'(jread), 1);
        icmplt = 1;
        step(); icmplt = 0; #3;
        chk("right_cmplt_idle", 32'(cur_st), 0);

        // Tie with last=iutlb: dutlb wins; iutlb cmplt ignored while dutlb owns.
        step();
        ireq = 1; dreq = 1;
        dvpn = 28'h0abcdef; dasid = 16'h7777; dmode = 2'b00; dmach = 0; dread = 1;
        sb.push_back(exp_t'{1'b1, 28'h0abcdef, 16'h7777, 2'b00, 1'b0, 1'b1});
        #3;
        chk("tie2_dgrant", 32'(dgrant), 1);
        chk("tie2_igrant", 32'(igrant), 0);
        step(); dreq = 0; #3;
        chk("tie2_igrant_in_grant", 32'(igrant), 0);
        step(); icmplt = 1; #3;
        chk("tie2_igrant_in_busy", 32'(igrant), 0);
        step(); icmplt = 0; #3;
        chk("tie2_nonowner_ignored", 32'(cur_st), 2);
        dcmplt = 1; ireq = 0;
        step(); dcmplt = 0; #3;
        chk("tie2_idle", 32'(cur_st), 0);
        chk("tie2_no_op", 32'(no_op), 1);

        // Low power: blocks grant in IDLE; a granted transaction still completes.
        step();
        lpmd = 1; dreq = 1;
        dvpn = 28'h5555555; dasid = 16'h0001; dmode = 2'b01; dmach = 1; dread = 1;
        #3;
        chk("lpmd_no_dgrant", 32'(dgrant), 0);
        chk("lpmd_no_op", 32'(no_op), 0);
        step(); #3;
        chk("lpmd_still_idle", 32'(cur_st), 0);
        step(); lpmd = 0;
        sb.push_back(exp_t'{1'b1, 28'h5555555, 16'h0001, 2'b01, 1'b1, 1'b1});
        #3;
        chk("lpmd_drop_dgrant", 32'(dgrant), 1);
        step(); dreq = 0; lpmd = 1; #3;
        chk("lpmd_txn_grant", 32'(cur_st), 1);
        step(); #3;
        chk("lpmd_txn_busy", 32'(cur_st), 2);
        dcmplt = 1;
        step(); dcmplt = 0; #3;
        chk("lpmd_txn_done", 32'(cur_st), 0);

        // Request withdrawn before grant leaves no trace.
        ireq = 1;
        step(); ireq = 0;
        step(); lpmd = 0; #3;
        chk("drop_igrant", 32'(igrant), 0);
        chk("drop_state", 32'(cur_st), 0);

        // Reset mid-BUSY abandons the transaction; next tie goes to iutlb again.
        step();
        ireq = 1; ivpn = 28'h0c0ffee; iasid = 16'h4242; imode = 2'b10; imach = 0;
        sb.push_back(exp_t'{1'b0, 28'h0c0ffee, 16'h4242, 2'b10, 1'b0, 1'b1});
        #3;
        chk("g_igrant", 32'(igrant), 1);
        step(); ireq = 0;
        step(); #3;
        chk("g_busy", 32'(cur_st), 2);
        rst_b = 0;
        step(); rst_b = 1; #3;
        chk("mid_rst_state", 32'(cur_st), 0);
        chk("mid_rst_vpn",   32'(jvpn),   0);
        chk("mid_rst_asid",  32'(jasid),  0);
        chk("mid_rst_mode",  32'(jmode),  0);
        chk("mid_rst_read",  32'(jread),  0);
        chk("mid_rst_src",   32'(jsrc),   0);
        chk("mid_rst_jreq",  32'(jreq),   0);
        chk("mid_rst_no_op", 32'(no_op),  1);
        step();
        ireq = 1; dreq = 1;
        ivpn = 28'h0000abc; iasid = 16'h0c0c; imode = 2'b00; imach = 1;
        sb.push_back(exp_t'{1'b0, 28'h0000abc, 16'h0c0c, 2'b00, 1'b1, 1'b1});
        #3;
        chk("post_rst_tie_igrant", 32'(igrant), 1);
        chk("post_rst_tie_dgrant", 32'(dgrant), 0);
        step(); ireq = 0; dreq = 0;
        step(); icmplt = 1;
        step(); icmplt = 0; #3;
        chk("post_rst_idle", 32'(cur_st), 0);

        step(); step();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
